// File: rtl/clock_ratio_monitor_if.sv
// Interface between a divided clock under test and its ratio monitor.
// The master side drives the divided clock and observes the status; the
// slave side is the monitor itself, which samples sig_in and reports the
// measured period, high time and lock/loss status.
interface clock_ratio_monitor_if #(
    parameter int CNT_W = 8
);

    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             ratio_ok;
    logic             locked;
    logic             lost;

    modport master (
        output sig_in,
        input  period,
        input  high_time,
        input  meas_valid,
        input  ratio_ok,
        input  locked,
        input  lost
    );

    modport slave (
        input  sig_in,
        output period,
        output high_time,
        output meas_valid,
        output ratio_ok,
        output locked,
        output lost
    );

endinterface

// File: rtl/clock_ratio_monitor.sv
// Receive-side checker for a divide-by-N clock. The divided clock is
// treated as data synchronous to clk_in: every period (rising edge to
// rising edge) and its high time are measured in clk_in cycles, compared
// against EXP_RATIO, and LOCK_CNT consecutive matches declare lock. If no
// rising edge arrives for TIMEOUT cycles the monitor reports loss of signal
// until the next edge. TIMEOUT must not exceed 2^CNT_W-1, otherwise the
// saturating period counter can never reach it.
module clock_ratio_monitor #(
    parameter int CNT_W     = 8,
    parameter int EXP_RATIO = 5,
    parameter int LOCK_CNT  = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk_in,
    input  logic                 rst,
    clock_ratio_monitor_if.slave mon
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  EXP_V     = CNT_W'(EXP_RATIO);
    localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0] LOCK_MAX  = GOOD_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_MEAS,
        ST_LOSS
    } state_t;

    state_t state, state_nx;

    logic s1, s2;
    logic rise;

    logic [CNT_W-1:0] cnt, hi;
    logic [CNT_W-1:0] cnt_inc, hi_inc;

    logic [GOOD_W-1:0] good, good_nx, good_inc;

    logic [CNT_W-1:0] period_q, period_nx;
    logic [CNT_W-1:0] high_q, high_nx;
    logic             valid_q, valid_nx;
    logic             ok_q, ok_nx;
    logic             locked_q, locked_nx;
    logic             lost_q, lost_nx;

    // A rising edge is a sample of 1 preceded by a sample of 0.
    assign rise = s1 & ~s2;

    // Both counters stick at all-ones rather than wrapping, so a very long
    // gap can never alias onto a short legal period.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign hi_inc  = (s1 && (hi != CNT_MAX)) ? hi + 1'b1 : hi;

    // Two-stage sample of the divided clock for edge detection.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= mon.sig_in;
            s2 <= s1;
        end
    end

    // Period and high-time counters, restarted at 1 on every rising edge.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt <= '0;
            hi  <= '0;
        end else if (rise) begin
            cnt <= CNT_W'(1);
            hi  <= CNT_W'(1);
        end else begin
            cnt <= cnt_inc;
            hi  <= hi_inc;
        end
    end

    // State and status register bank.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= ST_WAIT;
            good     <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            ok_q     <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            good     <= good_nx;
            period_q <= period_nx;
            high_q   <= high_nx;
            valid_q  <= valid_nx;
            ok_q     <= ok_nx;
            locked_q <= locked_nx;
            lost_q   <= lost_nx;
        end
    end

    // Next-state and status decode. The first edge after reset or after a
    // loss only starts counting, since the period it closes is unknown. A
    // rising edge takes priority over the timeout when both coincide.
    always_comb begin
        state_nx  = state;
        good_nx   = good;
        period_nx = period_q;
        high_nx   = high_q;
        valid_nx  = 1'b0;
        ok_nx     = ok_q;
        locked_nx = locked_q;
        lost_nx   = lost_q;
        good_inc  = (good == LOCK_MAX) ? good : good + 1'b1;

        case (state)
            ST_WAIT: begin
                if (rise) begin
                    state_nx = ST_MEAS;
                end
            end
            ST_MEAS: begin
                if (rise) begin
                    period_nx = cnt;
                    high_nx   = hi;
                    valid_nx  = 1'b1;
                    ok_nx     = (cnt == EXP_V);
                    good_nx   = (cnt == EXP_V) ? good_inc : '0;
                    locked_nx = (good_nx == LOCK_MAX);
                end else if (cnt == TIMEOUT_V) begin
                    state_nx  = ST_LOSS;
                    lost_nx   = 1'b1;
                    locked_nx = 1'b0;
                    ok_nx     = 1'b0;
                    good_nx   = '0;
                end
            end
            ST_LOSS: begin
                if (rise) begin
                    state_nx = ST_MEAS;
                    lost_nx  = 1'b0;
                end
            end
            default: begin
                state_nx = ST_WAIT;
            end
        endcase
    end

    assign mon.period     = period_q;
    assign mon.high_time  = high_q;
    assign mon.meas_valid = valid_q;
    assign mon.ratio_ok   = ok_q;
    assign mon.locked     = locked_q;
    assign mon.lost       = lost_q;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Directed bench for clock_ratio_monitor. Each table record describes one
// period of the divided clock (high cycles then low cycles) together with
// the status expected on its second cycle, which is where the measurement
// of the previous period appears. Loss of signal and mid-period reset are
// driven as hand-written sequences around the table.
module tb_clock_ratio_monitor;

    typedef struct {
        int         high_len;
        int         low_len;
        logic       exp_valid;
        logic [7:0] exp_period;
        logic [7:0] exp_high;
        logic       exp_ok;
        logic       exp_locked;
        logic       exp_lost;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst;

    int tests_run    = 0;
    int tests_failed = 0;

    vec_t main_tbl [19];
    vec_t relock_tbl [5];

    clock_ratio_monitor_if #(.CNT_W(8)) mon_if ();

    clock_ratio_monitor #(
        .CNT_W     (8),
        .EXP_RATIO (5),
        .LOCK_CNT  (4),
        .TIMEOUT   (64)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .mon    (mon_if)
    );

    always #5 clk_in = ~clk_in;

    // Safety net in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input int h, input int l, input logic v,
                                input logic [7:0] p, input logic [7:0] ht,
                                input logic ok, input logic lk, input logic ls);
        vec_t r;
        r.high_len   = h;
        r.low_len    = l;
        r.exp_valid  = v;
        r.exp_period = p;
        r.exp_high   = ht;
        r.exp_ok     = ok;
        r.exp_locked = lk;
        r.exp_lost   = ls;
        return r;
    endfunction

    // Drive one input vector, clock it in, and settle just after the edge.
    task automatic apply_stimulus(input logic r, input logic s);
        rst           = r;
        mon_if.sig_in = s;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, ".period"},     32'(mon_if.period),     32'd0);
        check_output({tag, ".high_time"},  32'(mon_if.high_time),  32'd0);
        check_output({tag, ".meas_valid"}, 32'(mon_if.meas_valid), 32'd0);
        check_output({tag, ".ratio_ok"},   32'(mon_if.ratio_ok),   32'd0);
        check_output({tag, ".locked"},     32'(mon_if.locked),     32'd0);
        check_output({tag, ".lost"},       32'(mon_if.lost),       32'd0);
    endtask

    // Play one period of the divided clock and check the measurement that
    // lands on its second cycle; every other cycle must carry no pulse.
    task automatic run_record(input vec_t v, input string tag);
        for (int i = 0; i < v.high_len + v.low_len; i++) begin
            apply_stimulus(1'b0, (i < v.high_len) ? 1'b1 : 1'b0);
            if (i == 1) begin
                check_output({tag, ".meas_valid"}, 32'(mon_if.meas_valid), 32'(v.exp_valid));
                check_output({tag, ".period"},     32'(mon_if.period),     32'(v.exp_period));
                check_output({tag, ".high_time"},  32'(mon_if.high_time),  32'(v.exp_high));
                check_output({tag, ".ratio_ok"},   32'(mon_if.ratio_ok),   32'(v.exp_ok));
                check_output({tag, ".locked"},     32'(mon_if.locked),     32'(v.exp_locked));
                check_output({tag, ".lost"},       32'(mon_if.lost),       32'(v.exp_lost));
            end else begin
                check_output($sformatf("%s.idle%0d", tag, i), 32'(mon_if.meas_valid), 32'd0);
            end
        end
    endtask

    initial begin
        // Lock on divide-by-5, break it with one period of 4, relock, then
        // run the minimum legal period of 2 and lock once more.
        main_tbl[0]  = mk(2, 3, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        main_tbl[1]  = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0);
        main_tbl[2]  = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0);
        main_tbl[3]  = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0);
        main_tbl[4]  = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b1, 1'b0);
        main_tbl[5]  = mk(1, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b1, 1'b0);
        main_tbl[6]  = mk(2, 3, 1'b1, 8'd4, 8'd1, 1'b0, 1'b0, 1'b0);
        main_tbl[7]  = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0);
        main_tbl[8]  = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0);
        main_tbl[9]  = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0);
        main_tbl[10] = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b1, 1'b0);
        main_tbl[11] = mk(1, 1, 1'b1, 8'd5, 8'd2, 1'b1, 1'b1, 1'b0);
        main_tbl[12] = mk(1, 1, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0);
        main_tbl[13] = mk(1, 1, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0);
        main_tbl[14] = mk(2, 3, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0);
        main_tbl[15] = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0);
        main_tbl[16] = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0);
        main_tbl[17] = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0);
        main_tbl[18] = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b1, 1'b0);

        // After a reset: one silent rise, then four matches to lock.
        relock_tbl[0] = mk(2, 3, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        relock_tbl[1] = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0);
        relock_tbl[2] = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0);
        relock_tbl[3] = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0);
        relock_tbl[4] = mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b1, 1'b0);

        rst           = 1'b1;
        mon_if.sig_in = 1'b0;

        // Initial reset with the input toggling.
        apply_stimulus(1'b1, 1'b1);
        check_all_zero("reset0");
        apply_stimulus(1'b1, 1'b0);
        check_all_zero("reset1");

        for (int k = 0; k < 19; k++) begin
            run_record(main_tbl[k], $sformatf("main%0d", k));
        end

        // Loss of signal: one rise, then hold low past the timeout.
        apply_stimulus(1'b0, 1'b1);
        check_output("loss.step0_valid", 32'(mon_if.meas_valid), 32'd0);
        apply_stimulus(1'b0, 1'b1);
        check_output("loss.step1_valid",  32'(mon_if.meas_valid), 32'd1);
        check_output("loss.step1_period", 32'(mon_if.period),     32'd5);
        check_output("loss.step1_locked", 32'(mon_if.locked),     32'd1);
        for (int step = 2; step <= 70; step++) begin
            apply_stimulus(1'b0, 1'b0);
            if (step < 65) begin
                check_output($sformatf("loss.pre%0d_lost", step), 32'(mon_if.lost), 32'd0);
            end else begin
                check_output($sformatf("loss.post%0d_lost", step), 32'(mon_if.lost), 32'd1);
            end
            if (step == 64) begin
                check_output("loss.step64_locked", 32'(mon_if.locked), 32'd1);
            end
            if (step == 65) begin
                check_output("loss.step65_locked", 32'(mon_if.locked),     32'd0);
                check_output("loss.step65_ok",     32'(mon_if.ratio_ok),   32'd0);
                check_output("loss.step65_period", 32'(mon_if.period),     32'd5);
                check_output("loss.step65_high",   32'(mon_if.high_time),  32'd2);
                check_output("loss.step65_valid",  32'(mon_if.meas_valid), 32'd0);
            end
        end

        // Recovery: the first rise clears loss silently, the next measures.
        run_record(mk(2, 3, 1'b0, 8'd5, 8'd2, 1'b0, 1'b0, 1'b0), "recover");
        run_record(mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0), "recA");
        run_record(mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0), "recB");
        run_record(mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0), "recC");
        run_record(mk(2, 3, 1'b1, 8'd5, 8'd2, 1'b1, 1'b1, 1'b0), "recD");

        // Reset for 20 cycles part-way through a locked period.
        apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        check_output("mid.locked_before", 32'(mon_if.locked), 32'd1);
        apply_stimulus(1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(1'b1, (((k + 3) % 5) < 2) ? 1'b1 : 1'b0);
            check_all_zero($sformatf("midrst%0d", k));
        end
        for (int k = 0; k < 5; k++) begin
            run_record(relock_tbl[k], $sformatf("relock%0d", k));
        end

        // Rising edge coinciding with the timeout count: measurement wins.
        run_record(mk(1, 63, 1'b1, 8'd5,  8'd2, 1'b1, 1'b1, 1'b0), "edge63");
        run_record(mk(2, 3,  1'b1, 8'd64, 8'd1, 1'b0, 1'b0, 1'b0), "edge64");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
